// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: bus widths, storage depth,
// default wait-state count and the responder FSM state encoding.
package mem_responder_pkg;

  localparam int ADDR_W          = 6;
  localparam int DATA_W          = 8;
  localparam int DEPTH           = 1 << ADDR_W;
  localparam int WAIT_CYCLES_DEF = 2;
  // Wide enough for the largest legal wait-state count (15).
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between a CPU/program loader (master) and the memory responder
// (slave).
//   CPU side   : address, read, write, wdata -> ; <- rdata, ready, err
//   Loader side: ld_valid, ld_addr, ld_data   -> ; <- ld_ready
//
// Handshake semantics:
//   CPU    - read/write act as a request held by the master until it sees
//            ready=1. ready is a single-cycle completion pulse. rdata is
//            meaningful only while ready=1; err pulses with ready when the
//            request had read and write both high.
//   Loader - ld_valid/ld_ready is a strict valid/ready pair: a loader write
//            transfers on a rising edge where both are high. The master keeps
//            ld_addr/ld_data stable while ld_valid=1 and ld_ready=0.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  modport master (
    output address, read, write, wdata, ld_valid, ld_addr, ld_data,
    input  rdata, ready, err, ld_ready
  );

  modport slave (
    input  address, read, write, wdata, ld_valid, ld_addr, ld_data,
    output rdata, ready, err, ld_ready
  );

endinterface

// File: rtl/mem_array.sv
// 64 x 8 storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
//   clk   - write clock
//   we    - write enable, sampled on the rising edge
//   waddr - write address, wdata - write data
//   raddr - read address, rdata - combinational read data
module mem_array
  import mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts single CPU read/write requests, inserts
// WAIT_CYCLES wait states, then returns a one-cycle ready pulse. A program
// loader may write the array whenever the responder is idle and the CPU is
// not requesting.
//   clk       - single clock, rising edge
//   reset     - synchronous, active-low
//   bus       - mem_responder_if.slave (CPU + loader ports)
//   dbg_state - current FSM state for observation
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_responder_if.slave        bus,
  output state_e                dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              is_err_q, is_err_d;

  logic              cpu_req;
  logic              ld_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign cpu_req   = bus.read | bus.write;
  // CPU wins over the loader; the loader is also stalled outside IDLE.
  assign ld_accept = reset & (state_q == IDLE) & bus.ld_valid & ~cpu_req;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    is_err_d = is_err_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d   = bus.address;
          wdata_d  = bus.wdata;
          // read+write together is handled as a write and flagged.
          is_wr_d  = bus.write;
          is_err_d = bus.read & bus.write;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-port mux. A CPU write commits on the edge entering RESP: with no
  // wait states that is the acceptance edge, so the live bus is used;
  // otherwise the captured registers are used. Reset gates every write so an
  // aborted request never reaches the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.ld_addr;
    mem_wdata = bus.ld_data;
    if (reset) begin
      if ((WAIT_CYCLES == 0) && (state_q == IDLE) && bus.write) begin
        mem_we    = 1'b1;
        mem_waddr = bus.address;
        mem_wdata = bus.wdata;
      end else if ((state_q == WAIT) && (cnt_q == '0) && is_wr_q) begin
        mem_we    = 1'b1;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
      end else if (ld_accept) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      is_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      is_wr_q  <= is_wr_d;
      is_err_q <= is_err_d;
    end
  end

  mem_array u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

  assign bus.ready    = (state_q == RESP);
  assign bus.err      = (state_q == RESP) & is_err_q;
  assign bus.rdata    = ((state_q == RESP) && !is_wr_q) ? mem_rdata : '0;
  assign bus.ld_ready = ld_accept;
  assign dbg_state    = state_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of wait states inserted before a response, legal range 0..15.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 address  input  6  SHALL be the word address from the CPU AR register.
REQ-005 read  input  1  SHALL be the CPU read request.
REQ-006 write  input  1  SHALL be the CPU write request.
REQ-007 wdata  input  8  SHALL be the CPU write data.
REQ-008 rdata  output  8  SHALL be the read data, valid only while ready=1.
REQ-009 ready  output  1  SHALL be a one-cycle completion pulse for an accepted read or write.
REQ-010 err  output  1  SHALL be a one-cycle pulse flagging a request with read=1 and write=1.
REQ-011 ld_valid  input  1  SHALL be the program-loader write strobe.
REQ-012 ld_addr  input  6  SHALL be the loader address.
REQ-013 ld_data  input  8  SHALL be the loader data.
REQ-014 ld_ready  output  1  SHALL be high in every cycle in which a loader write is accepted.

Function
REQ-015 Storage SHALL be 64 words x 8 bits, addressed 0..63; there is no out-of-range address.
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-017 In IDLE, read or write high at a rising edge SHALL accept the request and capture address, wdata and request type.
REQ-018 On acceptance, the FSM SHALL go to RESP if WAIT_CYCLES=0, else load the wait counter with WAIT_CYCLES-1 and go to WAIT.
REQ-019 In WAIT, the counter SHALL decrement each edge, and the FSM SHALL go to RESP on the edge where the counter equals 0.
REQ-020 Net effect: ready SHALL be high in the cycle following edge E0+WAIT_CYCLES, where E0 is the acceptance edge.
REQ-021 In RESP, ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-022 A request present during RESP SHALL NOT be accepted; the earliest re-acceptance is the edge leaving IDLE.
REQ-023 For an accepted read, rdata SHALL equal the word at the captured address as of the RESP cycle; otherwise rdata SHALL be 8'h00.
REQ-024 For an accepted write, the array SHALL be written on the edge entering RESP, and rdata SHALL be 8'h00 during RESP.
REQ-025 read=write=1 at acceptance SHALL be treated as a write, and err SHALL pulse in the same cycle as ready.
REQ-026 Requests arriving in WAIT or RESP SHALL be ignored, not queued; the CPU holds its request until ready.
REQ-027 A loader write (ld_valid=1) SHALL be accepted only in IDLE with read=write=0, writing ld_data to ld_addr on that edge; ld_ready SHALL be combinationally high in that cycle.
REQ-028 A CPU request SHALL have priority over the loader in the same IDLE cycle; ld_ready=0 and the loader holds.
REQ-029 ld_valid in WAIT or RESP SHALL be stalled (ld_ready=0).
REQ-030 A read of an address written by the loader on an earlier edge SHALL return the new data.

Reset
REQ-031 While reset=0 at a rising edge, the state SHALL go to IDLE, the counter to 0, ready=0, err=0 and rdata=8'h00.
REQ-032 Reset SHALL abort any request in WAIT or RESP with no ready pulse; a pending write not yet committed SHALL NOT modify memory.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 ld_ready SHALL be 0 while reset=0.

Structure
REQ-035 A shared package SHALL hold ADDR_W=6, DATA_W=8, the state enumeration {IDLE, WAIT, RESP} and the default WAIT_CYCLES.
REQ-036 The storage SHALL be a sub-module mem_array: 64x8, one synchronous write port, one asynchronous read port.
REQ-037 mem_responder SHALL contain the FSM, wait counter, capture registers and write-port mux.

Verification
REQ-038 Loader writes 8'hA5@6'h03; WAIT_CYCLES=2; CPU read 6'h03 accepted at E0 -> ready=1 and rdata=8'hA5 in the cycle after E2 only.
REQ-039 WAIT_CYCLES=0: CPU write 8'h3C@6'h10, then read 6'h10 -> each ready arrives the cycle after acceptance; read returns 8'h3C.
REQ-040 read=write=1, wdata=8'h77@6'h01 -> err and ready pulse together; a subsequent read of 6'h01 returns 8'h77.
REQ-041 ld_valid and read asserted in the same IDLE cycle -> read accepted, ld_ready=0 until IDLE with no request; loader write then completes.
REQ-042 reset=0 during WAIT of a write of 8'hFF@6'h20 whose address previously held 8'h11 -> no ready pulse; a later read returns 8'h11.
REQ-043 read held high continuously -> exactly one ready per 2+WAIT_CYCLES cycles, with no back-to-back ready pulses.
